// File: rtl/issue_ctrl.sv
// issue_ctrl: in-order issue gate with scoreboard hazard check, a
// round-robin register-file write-port arbiter and a flush/drain FSM.
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   dec_valid/dec_ready            decode handshake
//   dec_rs1/rs2/rd, dec_use_*      operand indices and live flags
//   dec_fu, fu_ready, fu_issue     FU selection, per-FU ready, issue strobe
//   using, setusing, finish        scoreboard busy vector, set/clear pulses
//   wb_req, wb_rd, wb_gnt          per-FU write-port request/index/grant
//   rf_we, rf_waddr                register-file write port
//   flush, drained                 drain request and drain-complete flag
//   stall_cnt                      saturating count of stalled cycles
module issue_ctrl #(
    parameter int NFU        = 3,
    parameter int REG_NUMBER = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   dec_valid,
    output logic                   dec_ready,
    input  logic [4:0]             dec_rs1,
    input  logic [4:0]             dec_rs2,
    input  logic [4:0]             dec_rd,
    input  logic                   dec_use_rs1,
    input  logic                   dec_use_rs2,
    input  logic                   dec_use_rd,
    input  logic [$clog2(NFU)-1:0] dec_fu,
    input  logic [NFU-1:0]         fu_ready,
    output logic [NFU-1:0]         fu_issue,
    input  logic [REG_NUMBER-1:0]  using,
    output logic [REG_NUMBER-1:0]  setusing,
    output logic [REG_NUMBER-1:0]  finish,
    input  logic [NFU-1:0]         wb_req,
    input  logic [NFU*5-1:0]       wb_rd,
    output logic [NFU-1:0]         wb_gnt,
    output logic                   rf_we,
    output logic [4:0]             rf_waddr,
    input  logic                   flush,
    output logic                   drained,
    output logic [15:0]            stall_cnt
);

    localparam int FW = $clog2(NFU);

    localparam logic [1:0] S_RUN   = 2'd0;
    localparam logic [1:0] S_STALL = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]    r_state;
    logic [1:0]    w_state_nxt;
    logic [FW-1:0] r_rr_ptr;
    logic [FW-1:0] w_rr_nxt;
    logic [15:0]   r_stall_cnt;

    logic          w_hazard;
    logic          w_fu_rdy;
    logic          w_ready;
    logic          w_xfer;
    logic          w_stall;
    logic          w_gnt_any;
    logic [FW-1:0] w_gnt_idx;
    logic [FW-1:0] w_cand;
    logic [4:0]    w_gnt_rd;

    // x0 never carries a dependency, whatever the scoreboard says.
    always_comb begin
        w_hazard = 1'b0;
        if (dec_use_rs1 && (dec_rs1 != 5'd0) && using[dec_rs1])
            w_hazard = 1'b1;
        if (dec_use_rs2 && (dec_rs2 != 5'd0) && using[dec_rs2])
            w_hazard = 1'b1;
        if (dec_use_rd && (dec_rd != 5'd0) && using[dec_rd])
            w_hazard = 1'b1;
    end

    // An index with no matching FU reads as not ready.
    always_comb begin
        w_fu_rdy = 1'b0;
        for (int i = 0; i < NFU; i++) begin
            if (dec_fu == FW'(i))
                w_fu_rdy = fu_ready[i];
        end
    end

    assign w_ready = (r_state != S_DRAIN) && !w_hazard && w_fu_rdy;
    assign w_xfer  = dec_valid && w_ready;
    assign w_stall = dec_valid && !w_ready;

    // Round-robin search starting at r_rr_ptr; first requester wins.
    always_comb begin
        w_gnt_any = 1'b0;
        w_gnt_idx = '0;
        w_cand    = '0;
        for (int k = 0; k < NFU; k++) begin
            w_cand = FW'((int'(r_rr_ptr) + k) % NFU);
            if (!w_gnt_any && wb_req[w_cand]) begin
                w_gnt_any = 1'b1;
                w_gnt_idx = w_cand;
            end
        end
    end

    always_comb begin
        w_gnt_rd = 5'd0;
        for (int i = 0; i < NFU; i++) begin
            if (w_gnt_idx == FW'(i))
                w_gnt_rd = wb_rd[5*i +: 5];
        end
    end

    always_comb begin
        w_rr_nxt = r_rr_ptr;
        if (w_gnt_any) begin
            if (w_gnt_idx == FW'(NFU - 1))
                w_rr_nxt = '0;
            else
                w_rr_nxt = w_gnt_idx + FW'(1);
        end
    end

    // Every strobe is gated by rst_n so an asynchronous reset that
    // lands mid-cycle also cancels the pulses of that cycle.
    always_comb begin
        fu_issue = '0;
        setusing = '0;
        finish   = '0;
        wb_gnt   = '0;
        rf_we    = 1'b0;
        rf_waddr = 5'd0;
        if (rst_n) begin
            if (w_xfer) begin
                for (int i = 0; i < NFU; i++) begin
                    if (dec_fu == FW'(i))
                        fu_issue[i] = 1'b1;
                end
                if (dec_use_rd && (dec_rd != 5'd0))
                    setusing[dec_rd] = 1'b1;
            end
            if (w_gnt_any) begin
                wb_gnt[w_gnt_idx] = 1'b1;
                rf_we             = 1'b1;
                rf_waddr          = w_gnt_rd;
                if (w_gnt_rd != 5'd0)
                    finish[w_gnt_rd] = 1'b1;
            end
        end
    end

    assign dec_ready = rst_n && w_ready;
    assign drained   = rst_n && (r_state == S_DRAIN) && (using == '0);
    assign stall_cnt = r_stall_cnt;

    // flush outranks every other transition, including DRAIN exit.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_RUN: begin
                if (flush)
                    w_state_nxt = S_DRAIN;
                else if (w_stall)
                    w_state_nxt = S_STALL;
            end
            S_STALL: begin
                if (flush)
                    w_state_nxt = S_DRAIN;
                else if (w_xfer)
                    w_state_nxt = S_RUN;
            end
            S_DRAIN: begin
                if (!flush && (using == '0))
                    w_state_nxt = S_RUN;
            end
            default: w_state_nxt = S_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_RUN;
            r_rr_ptr    <= '0;
            r_stall_cnt <= 16'd0;
        end else begin
            r_state  <= w_state_nxt;
            r_rr_ptr <= w_rr_nxt;
            if ((r_state != S_DRAIN) && w_stall
                && (r_stall_cnt != 16'hFFFF))
                r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_issue_ctrl.sv
// tb_issue_ctrl: scoreboard bench for issue_ctrl; a queue of expected
// per-cycle responses is filled by the driver and drained by a monitor.
module tb_issue_ctrl;

    typedef struct packed {
        logic        rdy;
        logic [2:0]  iss;
        logic [31:0] su;
        logic [31:0] fi;
        logic [2:0]  gnt;
        logic        we;
        logic [4:0]  waddr;
        logic        drn;
        logic [15:0] cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        dec_valid = 1'b0;
    logic        dec_ready;
    logic [4:0]  dec_rs1 = '0;
    logic [4:0]  dec_rs2 = '0;
    logic [4:0]  dec_rd = '0;
    logic        dec_use_rs1 = 1'b0;
    logic        dec_use_rs2 = 1'b0;
    logic        dec_use_rd = 1'b0;
    logic [1:0]  dec_fu = '0;
    logic [2:0]  fu_ready = 3'b111;
    logic [2:0]  fu_issue;
    logic [31:0] using_v = '0;
    logic [31:0] setusing_o;
    logic [31:0] finish_o;
    logic [2:0]  wb_req = '0;
    logic [14:0] wb_rd = '0;
    logic [2:0]  wb_gnt;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic        flush = 1'b0;
    logic        drained;
    logic [15:0] stall_cnt;

    always #5 clk = ~clk;

    issue_ctrl #(.NFU(3), .REG_NUMBER(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .dec_valid   (dec_valid),
        .dec_ready   (dec_ready),
        .dec_rs1     (dec_rs1),
        .dec_rs2     (dec_rs2),
        .dec_rd      (dec_rd),
        .dec_use_rs1 (dec_use_rs1),
        .dec_use_rs2 (dec_use_rs2),
        .dec_use_rd  (dec_use_rd),
        .dec_fu      (dec_fu),
        .fu_ready    (fu_ready),
        .fu_issue    (fu_issue),
        .using       (using_v),
        .setusing    (setusing_o),
        .finish      (finish_o),
        .wb_req      (wb_req),
        .wb_rd       (wb_rd),
        .wb_gnt      (wb_gnt),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .flush       (flush),
        .drained     (drained),
        .stall_cnt   (stall_cnt)
    );

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail = 0;

    // Reference state: the bench plays the scoreboard and the FUs.
    logic [31:0] busy = '0;
    bit          force0 = 1'b0;
    bit          m_drain = 1'b0;
    int          m_rr = 0;
    int          m_cnt = 0;
    int          pend[3][$];

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
        end
    endtask

    // One cycle: apply rst, predict outputs from current model state,
    // queue the prediction, advance the model, move to next cycle.
    task automatic step(input bit rst);
        exp_t       e;
        int         g;
        int         idx;
        logic [4:0] wrd;
        bit         haz;
        bit         fok;
        bit         rdy;
        bit         xfer;
        e = '0;
        rst_n = rst;
        if (!rst) begin
            busy = '0;
            m_drain = 1'b0;
            m_rr = 0;
            m_cnt = 0;
            for (int i = 0; i < 3; i++) pend[i].delete();
            using_v = {31'd0, force0};
        end else begin
            using_v = busy | {31'd0, force0};
            haz = (dec_use_rs1 && dec_rs1 != 0 && using_v[dec_rs1])
               || (dec_use_rs2 && dec_rs2 != 0 && using_v[dec_rs2])
               || (dec_use_rd && dec_rd != 0 && using_v[dec_rd]);
            fok = (dec_fu < 3) && fu_ready[dec_fu];
            rdy = !m_drain && !haz && fok;
            xfer = dec_valid && rdy;
            e.rdy = rdy;
            if (xfer) begin
                e.iss = 3'b001 << dec_fu;
                if (dec_use_rd && dec_rd != 0)
                    e.su = 32'd1 << dec_rd;
            end
            g = -1;
            for (int k = 0; k < 3; k++) begin
                idx = (m_rr + k) % 3;
                if (g < 0 && wb_req[idx]) g = idx;
            end
            if (g >= 0) begin
                wrd = wb_rd[5*g +: 5];
                e.gnt = 3'b001 << g;
                e.we = 1'b1;
                e.waddr = wrd;
                if (wrd != 0) e.fi = 32'd1 << wrd;
            end
            e.drn = m_drain && (using_v == 0);
            e.cnt = 16'(m_cnt);
            if (!m_drain && dec_valid && !rdy && m_cnt < 65535)
                m_cnt++;
            m_drain = flush || (m_drain && using_v != 0);
            if (g >= 0) begin
                m_rr = (g + 1) % 3;
                if (pend[g].size() > 0) void'(pend[g].pop_front());
            end
            busy = (busy | e.su) & ~e.fi;
            if (xfer && dec_use_rd) pend[dec_fu].push_back(int'(dec_rd));
        end
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        dec_valid = 1'b0;
        dec_use_rs1 = 1'b0;
        dec_use_rs2 = 1'b0;
        dec_use_rd = 1'b0;
        dec_rs1 = '0;
        dec_rs2 = '0;
        dec_rd = '0;
        dec_fu = '0;
        fu_ready = 3'b111;
        wb_req = '0;
        wb_rd = '0;
        flush = 1'b0;
        force0 = 1'b0;
    endtask

    task automatic instr(input int fu, input bit u1, input int r1,
                         input bit u2, input int r2,
                         input bit ud, input int rd);
        dec_valid = 1'b1;
        dec_fu = 2'(fu);
        dec_use_rs1 = u1;
        dec_rs1 = 5'(r1);
        dec_use_rs2 = u2;
        dec_rs2 = 5'(r2);
        dec_use_rd = ud;
        dec_rd = 5'(rd);
    endtask

    task automatic wb(input int fu, input int rd);
        wb_req = '0;
        wb_rd = '0;
        wb_req[fu] = 1'b1;
        wb_rd[5*fu +: 5] = 5'(rd);
    endtask

    task automatic auto_wb();
        wb_req = '0;
        wb_rd = '0;
        for (int f = 0; f < 3; f++) begin
            if (pend[f].size() > 0 && $urandom_range(0, 2) != 0) begin
                wb_req[f] = 1'b1;
                wb_rd[5*f +: 5] = 5'(pend[f][0]);
            end
        end
    endtask

    // Monitor: compares whatever the DUT presents against the queue.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("dec_ready", 64'(dec_ready), 64'(e.rdy));
                chk("fu_issue", 64'(fu_issue), 64'(e.iss));
                chk("setusing", 64'(setusing_o), 64'(e.su));
                chk("finish", 64'(finish_o), 64'(e.fi));
                chk("wb_gnt", 64'(wb_gnt), 64'(e.gnt));
                chk("rf_we", 64'(rf_we), 64'(e.we));
                chk("rf_waddr", 64'(rf_waddr), 64'(e.waddr));
                chk("drained", 64'(drained), 64'(e.drn));
                chk("stall_cnt", 64'(stall_cnt), 64'(e.cnt));
            end
        end
    end

    initial begin
        int guard;
        idle();
        @(posedge clk);
        #1;

        // reset with live-looking inputs: all strobes must stay low
        instr(0, 1'b0, 0, 1'b0, 0, 1'b1, 7);
        wb_req = 3'b111;
        wb_rd = {5'd3, 5'd2, 5'd1};
        repeat (3) step(1'b0);

        // round-robin from reset: 001 010 100 001 010 100
        idle();
        wb_req = 3'b111;
        repeat (6) step(1'b1);

        // back-to-back RAW on x5
        idle();
        instr(0, 1'b0, 0, 1'b0, 0, 1'b1, 5);
        step(1'b1);
        instr(1, 1'b1, 5, 1'b0, 0, 1'b1, 9);
        repeat (3) step(1'b1);
        wb(0, 5);
        step(1'b1);
        wb_req = '0;
        wb_rd = '0;
        step(1'b1);
        idle();
        wb(1, 9);
        step(1'b1);
        idle();
        step(1'b1);

        // x0 with using[0] forced high
        force0 = 1'b1;
        instr(2, 1'b1, 0, 1'b0, 0, 1'b1, 0);
        step(1'b1);
        idle();
        force0 = 1'b1;
        step(1'b1);
        wb(2, 0);
        step(1'b1);
        idle();
        step(1'b1);

        // flush with x5 and x6 outstanding
        instr(0, 1'b0, 0, 1'b0, 0, 1'b1, 5);
        step(1'b1);
        instr(2, 1'b0, 0, 1'b0, 0, 1'b1, 6);
        step(1'b1);
        idle();
        flush = 1'b1;
        step(1'b1);
        flush = 1'b0;
        instr(1, 1'b0, 0, 1'b0, 0, 1'b0, 0);
        repeat (2) step(1'b1);
        wb(0, 5);
        step(1'b1);
        wb(2, 6);
        step(1'b1);
        wb_req = '0;
        wb_rd = '0;
        repeat (2) step(1'b1);
        idle();
        step(1'b1);

        // FU1 busy, then ready
        instr(1, 1'b0, 0, 1'b0, 0, 1'b1, 10);
        fu_ready = 3'b101;
        repeat (3) step(1'b1);
        fu_ready = 3'b111;
        step(1'b1);
        idle();
        wb(1, 10);
        step(1'b1);
        idle();
        step(1'b1);

        // reset dropped in the middle of a transfer + grant cycle
        instr(0, 1'b0, 0, 1'b0, 0, 1'b1, 11);
        wb(1, 12);
        #2;
        step(1'b0);
        idle();
        step(1'b0);
        step(1'b1);

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 9) < 7)
                instr($urandom_range(0, 2),
                      1'($urandom_range(0, 1)), $urandom_range(0, 7),
                      1'($urandom_range(0, 1)), $urandom_range(0, 7),
                      1'($urandom_range(0, 1)), $urandom_range(0, 7));
            else
                dec_valid = 1'b0;
            fu_ready = 3'($urandom_range(0, 7)) | 3'($urandom_range(0, 7));
            flush = ($urandom_range(0, 49) == 0);
            force0 = ($urandom_range(0, 9) == 0);
            auto_wb();
            step(1'b1);
        end

        // let outstanding writebacks retire, bounded
        idle();
        guard = 0;
        while ((busy != 0 || m_drain) && guard < 300) begin
            auto_wb();
            step(1'b1);
            guard++;
        end
        chk("drain_bound", 64'(busy != 0 || m_drain), 64'(0));

        // saturation: permanent hazard on x3
        idle();
        step(1'b0);
        busy = 32'd1 << 3;
        instr(0, 1'b1, 3, 1'b0, 0, 1'b0, 0);
        repeat (70000) step(1'b1);
        step(1'b0);
        instr(0, 1'b1, 3, 1'b0, 0, 1'b0, 0);
        step(1'b1);
        idle();
        step(1'b1);

        @(negedge clk);
        #1;
        chk("queue_empty", 64'(q.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
